dm_cache: RTL and testbench
===========================

# dm_cache

Direct-mapped, write-through, no-write-allocate data cache placed between the CPU load/store port and `mem_interface`. Read hits complete in the request cycle. Read misses stall the CPU and fetch one word through `mem_interface`. Writes always go through to memory and update the line only on a hit. One 32-bit word per line, with valid bits and tag stored in registers.

## Interface
- `ADDR_W`, 32, byte address width on both sides.
- `DATA_W`, 32, data word width.
- `IDX_W`, 4, index bits; the cache has 2^IDX_W lines (default 16).
- `CNT_W`, 16, width of each performance counter.

- `iCLK`  in  1  clock.
- `iRST_n`  in  1  asynchronous active-low reset.
- `cpu_addr`  in  ADDR_W  byte address; must be held stable while `cpu_stall`=1.
- `cpu_read`  in  1  load request.
- `cpu_write`  in  1  store request.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_rdata`  out  DATA_W  load data; valid when `cpu_read`=1 and `cpu_stall`=0.
- `cpu_stall`  out  1  CPU must hold its request.
- `cache_flush`  in  1  invalidate all lines.
- `mem_addr`  out  ADDR_W  word-aligned address to `mem_interface`.
- `mem_MemRead`  out  1  memory read strobe.
- `mem_MemWrite`  out  1  memory write strobe.
- `mem_data_in`  out  DATA_W  write data to memory.
- `mem_data_out`  in  DATA_W  read data from memory.
- `mem_wait`  in  1  memory not ready to accept a request.
- `mem_rvalid`  in  1  one-cycle pulse; `mem_data_out` is valid in that cycle.
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating read hit and read miss counters.

## Operation
- Address split:
  - index = `cpu_addr[IDX_W+1:2]`
  - tag = `cpu_addr[ADDR_W-1:IDX_W+2]`
  - bits [1:0] are ignored.
- Hit = valid[index] && tag_arr[index]==tag (combinational).
- `mem_addr` = {`cpu_addr[ADDR_W-1:2]`, 2'b00}.
- States are IDLE, MISS, WRITE, WDONE.
- IDLE:
  - `cache_flush`=1: clear all valid bits at the clock edge. Any CPU request this cycle sees `cpu_stall`=1 and is retried next cycle.
  - Else `cpu_write`=1: `cpu_stall`=1, go to WRITE. Write has priority over a simultaneous `cpu_read`, which is ignored.
  - Else `cpu_read`=1 and hit: `cpu_stall`=0, `cpu_rdata`=data_arr[index], `hit_cnt`+1.
  - Else `cpu_read`=1 and miss: `cpu_stall`=1, `miss_cnt`+1, go to MISS.
- MISS:
  - `mem_MemRead`=1 and `cpu_stall`=1.
  - Data returns on `mem_rvalid`=1 (valid regardless of `mem_wait`). In that cycle write data_arr[index]=`mem_data_out`, tag_arr[index]=tag, valid[index]=1, and go to IDLE.
  - The re-evaluated request then hits in IDLE. That cycle does not increment `hit_cnt`; the MISS→IDLE transition sets a one-cycle suppress flag.
- WRITE:
  - `mem_MemWrite`=1, `mem_data_in`=`cpu_wdata`, `cpu_stall`=1.
  - The request is accepted in the first cycle with `mem_wait`=0. In that cycle, if hit, data_arr[index]=`cpu_wdata`. Go to WDONE.
  - A miss does not allocate and leaves the tags unchanged.
- WDONE:
  - One cycle with `cpu_stall`=0 and `mem_MemWrite`=0, then go to IDLE.
  - The CPU retires the store at this edge. Requests presented in WDONE are not evaluated.
- `cache_flush` outside IDLE is held off until IDLE only if still asserted; it is not latched.
- Counters saturate at all-ones and do not wrap.
- Outside IDLE, `cpu_rdata` = data_arr[index] (don't-care to the CPU).

## Timing
- Reset (async, `iRST_n`=0):
  - state=IDLE; all valid=0.
  - `mem_MemRead`=`mem_MemWrite`=0; `mem_data_in`=0.
  - `hit_cnt`=`miss_cnt`=0.
  - `cpu_stall`=0 with no request active.
  - Tag and data arrays are not reset.
- Reset mid-MISS or mid-WRITE aborts the access immediately. A late `mem_rvalid` arriving after reset is ignored because the block is in IDLE.
- `mem_MemRead` and `mem_MemWrite` are registered from state and are never high together.
- Read hit: latency 0, `cpu_stall` low in the request cycle.
- Read miss: `cpu_stall` high from the request cycle through the `mem_rvalid` cycle. Data reaches the CPU on the following IDLE cycle: latency = L+2 cycles from request, where L = cycles from `mem_MemRead` rising to `mem_rvalid`.
- Write: minimum 3 cycles (IDLE, WRITE with `mem_wait`=0, WDONE). Each `mem_wait` cycle adds one.
- A `mem_rvalid` pulse in any state other than MISS is ignored.

## Test plan
- After reset, read 0x0000_0040:
  - Miss: `mem_MemRead` high, `mem_addr`=0x40.
  - `mem_rvalid` with 0xDEADBEEF after 3 cycles.
  - `cpu_rdata`=0xDEADBEEF with `cpu_stall`=0 next cycle; `miss_cnt`=1, `hit_cnt`=0.
- Reread 0x40 → hit in the same cycle, no `mem_MemRead`, `hit_cnt`=1.
- Read 0x80 (same index 0, different tag) → miss, line replaced. Reread 0x40 → miss again.
- Write 0x12345678 to hit address 0x40 with `mem_wait` high for 2 cycles:
  - `mem_MemWrite` high 3 cycles, then WDONE stall=0.
  - A following read of 0x40 hits and returns 0x12345678.
- Write to a missing address 0x100, then read 0x100 → write goes to memory; the read misses (no allocate).
- Controls and reset:
  - `cache_flush` in IDLE, then read 0x40 → miss.
  - Assert `iRST_n`=0 during MISS → outputs go low immediately. A `mem_rvalid` after release does not set any valid bit.
  - Drive `hit_cnt` to 0xFFFF → further hits keep it at 0xFFFF.

Source files
------------

// File: rtl/dm_cache.sv
// rtl/dm_cache.sv - direct-mapped write-through no-write-allocate data cache
module dm_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cache_flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_wait,
  input  logic              mem_rvalid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, WRITE, WDONE} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             suppress;
  logic             hit_inc, miss_inc, flush_now, fill, wr_upd;
  logic             addr_unused;

  assign idx         = cpu_addr[IDX_W+1:2];
  assign tag         = cpu_addr[ADDR_W-1:IDX_W+2];
  assign hit         = valid[idx] && (tag_arr[idx] == tag);
  assign mem_addr    = {cpu_addr[ADDR_W-1:2], 2'b00};
  assign cpu_rdata   = data_arr[idx];
  assign mem_data_in = (state == WRITE) ? cpu_wdata : '0;
  assign addr_unused = ^cpu_addr[1:0];

  always_comb begin
    next_state = state;
    cpu_stall  = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    flush_now  = 1'b0;
    fill       = 1'b0;
    wr_upd     = 1'b0;
    case (state)
      IDLE: begin
        if (cache_flush) begin
          cpu_stall = 1'b1;
          flush_now = 1'b1;
        end else if (cpu_write) begin
          cpu_stall  = 1'b1;
          next_state = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            hit_inc = !suppress;
          end else begin
            cpu_stall  = 1'b1;
            miss_inc   = 1'b1;
            next_state = MISS;
          end
        end
      end
      MISS: begin
        cpu_stall = 1'b1;
        if (mem_rvalid) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (!mem_wait) begin
          wr_upd     = hit;
          next_state = WDONE;
        end
      end
      WDONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered alongside state so they drop the instant reset asserts.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= IDLE;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      suppress     <= 1'b0;
    end else begin
      state        <= next_state;
      mem_MemRead  <= (next_state == MISS);
      mem_MemWrite <= (next_state == WRITE);
      suppress     <= fill;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      valid <= '0;
    end else if (flush_now) begin
      valid <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (fill) begin
      data_arr[idx] <= mem_data_out;
      tag_arr[idx]  <= tag;
    end else if (wr_upd) begin
      data_arr[idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc && (hit_cnt != {CNT_W{1'b1}}))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_inc && (miss_cnt != {CNT_W{1'b1}}))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// tb/tb_dm_cache.sv - directed self-checking bench for dm_cache
module tb_dm_cache;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [31:0] cpu_addr;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        cache_flush;
  logic [31:0] mem_addr;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_wait, mem_rvalid;
  logic [15:0] hit_cnt, miss_cnt;

  int total  = 0;
  int passed = 0;

  always #5 iCLK = ~iCLK;

  dm_cache dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cache_flush(cache_flush),
    .mem_addr(mem_addr), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_wait(mem_wait), .mem_rvalid(mem_rvalid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Drives a fill: enters MISS, waits lat cycles after MemRead rises, pulses rvalid.
  task automatic fill(input logic [31:0] d, input int lat);
    tick();
    repeat (lat) tick();
    mem_rvalid   = 1'b1;
    mem_data_out = d;
    tick();
    mem_rvalid   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; cpu_addr = '0; cpu_read = 0; cpu_write = 0; cpu_wdata = '0;
    cache_flush = 0; mem_data_out = '0; mem_wait = 0; mem_rvalid = 0;
    #12;
    total++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", cpu_stall); else passed++;
    total++; if ({mem_MemRead, mem_MemWrite} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {mem_MemRead, mem_MemWrite}); else passed++;
    total++; if (mem_data_in !== 32'h0) $display("FAIL reset_data_in got %h exp 0", mem_data_in); else passed++;
    total++; if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL reset_counters got %h exp 0", {hit_cnt, miss_cnt}); else passed++;
    @(posedge iCLK); #1 iRST_n = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    cpu_addr = 32'h40; cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL miss_req_stall got %b exp 1", cpu_stall); else passed++;
    tick();
    total++; if (mem_MemRead !== 1'b1) $display("FAIL miss_memread got %b exp 1", mem_MemRead); else passed++;
    total++; if (mem_addr !== 32'h40) $display("FAIL miss_addr got %h exp 40", mem_addr); else passed++;
    total++; if (miss_cnt !== 16'd1) $display("FAIL miss_cnt1 got %0d exp 1", miss_cnt); else passed++;
    repeat (3) tick();
    total++; if (cpu_stall !== 1'b1) $display("FAIL miss_wait_stall got %b exp 1", cpu_stall); else passed++;
    mem_rvalid = 1; mem_data_out = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0; #1;
    total++; if (cpu_stall !== 1'b0) $display("FAIL miss_done_stall got %b exp 0", cpu_stall); else passed++;
    total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL miss_rdata got %h exp deadbeef", cpu_rdata); else passed++;
    total++; if (mem_MemRead !== 1'b0) $display("FAIL miss_done_memread got %b exp 0", mem_MemRead); else passed++;
    tick();
    cpu_read = 0; #1;
    total++; if (hit_cnt !== 16'd0) $display("FAIL miss_suppress_hit got %0d exp 0", hit_cnt); else passed++;
    tick();
  endtask

  task automatic test_read_hit();
    cpu_addr = 32'h40; cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b0) $display("FAIL hit_stall got %b exp 0", cpu_stall); else passed++;
    total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata got %h exp deadbeef", cpu_rdata); else passed++;
    tick();
    cpu_read = 0; #1;
    total++; if (mem_MemRead !== 1'b0) $display("FAIL hit_memread got %b exp 0", mem_MemRead); else passed++;
    total++; if (hit_cnt !== 16'd1) $display("FAIL hit_cnt1 got %0d exp 1", hit_cnt); else passed++;
  endtask

  task automatic test_conflict();
    cpu_addr = 32'h80; cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL conf_80_stall got %b exp 1", cpu_stall); else passed++;
    fill(32'hCAFEF00D, 1);
    total++; if (cpu_rdata !== 32'hCAFEF00D) $display("FAIL conf_80_rdata got %h exp cafef00d", cpu_rdata); else passed++;
    cpu_read = 0; tick();
    cpu_addr = 32'h40; cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL conf_40_stall got %b exp 1", cpu_stall); else passed++;
    fill(32'hDEADBEEF, 2);
    cpu_read = 0; tick();
    total++; if (miss_cnt !== 16'd3) $display("FAIL conf_miss_cnt got %0d exp 3", miss_cnt); else passed++;
    total++; if (hit_cnt !== 16'd1) $display("FAIL conf_hit_cnt got %0d exp 1", hit_cnt); else passed++;
  endtask

  task automatic test_write_hit();
    int wcnt;
    wcnt = 0;
    cpu_addr = 32'h40; cpu_wdata = 32'h12345678; cpu_write = 1; mem_wait = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL wr_req_stall got %b exp 1", cpu_stall); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_wait = 0;
      #1;
      if (mem_MemWrite === 1'b1) wcnt++;
      if (i == 0) begin
        total++; if (mem_data_in !== 32'h12345678) $display("FAIL wr_data_in got %h exp 12345678", mem_data_in); else passed++;
        total++; if (mem_MemRead !== 1'b0) $display("FAIL wr_no_memread got %b exp 0", mem_MemRead); else passed++;
      end
    end
    total++; if (wcnt !== 3) $display("FAIL wr_strobe_cycles got %0d exp 3", wcnt); else passed++;
    tick();
    total++; if (cpu_stall !== 1'b0) $display("FAIL wdone_stall got %b exp 0", cpu_stall); else passed++;
    total++; if (mem_MemWrite !== 1'b0) $display("FAIL wdone_memwrite got %b exp 0", mem_MemWrite); else passed++;
    cpu_write = 0; tick();
    cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b0) $display("FAIL wr_rd_stall got %b exp 0", cpu_stall); else passed++;
    total++; if (cpu_rdata !== 32'h12345678) $display("FAIL wr_rd_rdata got %h exp 12345678", cpu_rdata); else passed++;
    tick(); cpu_read = 0;
  endtask

  task automatic test_write_miss();
    cpu_addr = 32'h100; cpu_wdata = 32'hAAAA5555; cpu_write = 1; #1;
    tick();
    total++; if (mem_MemWrite !== 1'b1) $display("FAIL wm_memwrite got %b exp 1", mem_MemWrite); else passed++;
    total++; if (mem_addr !== 32'h100) $display("FAIL wm_addr got %h exp 100", mem_addr); else passed++;
    tick();
    cpu_write = 0; tick();
    cpu_addr = 32'h40; cpu_read = 1; #1;
    total++; if (cpu_rdata !== 32'h12345678 || cpu_stall !== 1'b0) $display("FAIL wm_tag_kept got %h/%b exp 12345678/0", cpu_rdata, cpu_stall); else passed++;
    tick();
    cpu_addr = 32'h100; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL wm_no_alloc got %b exp 1", cpu_stall); else passed++;
    fill(32'h0BADF00D, 0);
    total++; if (cpu_rdata !== 32'h0BADF00D) $display("FAIL wm_fill_rdata got %h exp 0badf00d", cpu_rdata); else passed++;
    cpu_read = 0; tick();
  endtask

  task automatic test_flush();
    cpu_addr = 32'h100; cpu_read = 1; cache_flush = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL flush_stall got %b exp 1", cpu_stall); else passed++;
    tick();
    cache_flush = 0; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL flush_miss got %b exp 1", cpu_stall); else passed++;
    total++; if (hit_cnt !== 16'd3) $display("FAIL flush_hit_cnt got %0d exp 3", hit_cnt); else passed++;
    total++; if (miss_cnt !== 16'd4) $display("FAIL flush_miss_cnt got %0d exp 4", miss_cnt); else passed++;
    tick();
    total++; if (mem_MemRead !== 1'b1 || miss_cnt !== 16'd5) $display("FAIL flush_refetch got %b/%0d exp 1/5", mem_MemRead, miss_cnt); else passed++;
  endtask

  task automatic test_reset_mid_miss();
    #2 iRST_n = 0; cpu_read = 0; #1;
    total++; if (mem_MemRead !== 1'b0) $display("FAIL rst_memread got %b exp 0", mem_MemRead); else passed++;
    total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", cpu_stall); else passed++;
    total++; if (miss_cnt !== 16'd0) $display("FAIL rst_miss_cnt got %0d exp 0", miss_cnt); else passed++;
    @(posedge iCLK); #1 iRST_n = 1;
    tick();
    mem_rvalid = 1; mem_data_out = 32'h99999999;
    tick();
    mem_rvalid = 0; cpu_addr = 32'h100; cpu_read = 1; #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL rst_late_rvalid got %b exp 1", cpu_stall); else passed++;
    tick();
    total++; if (mem_MemRead !== 1'b1 || miss_cnt !== 16'd1) $display("FAIL rst_refetch got %b/%0d exp 1/1", mem_MemRead, miss_cnt); else passed++;
  endtask

  task automatic test_saturate();
    int n;
    mem_rvalid = 1; mem_data_out = 32'h77;
    tick();
    mem_rvalid = 0; #1;
    n = 0;
    while (hit_cnt !== 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    total++; if (hit_cnt !== 16'hFFFF) $display("FAIL sat_reach got %h exp ffff after %0d cycles", hit_cnt, n); else passed++;
    repeat (3) tick();
    total++; if (hit_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", hit_cnt); else passed++;
    total++; if (cpu_rdata !== 32'h77 || cpu_stall !== 1'b0) $display("FAIL sat_rdata got %h/%b exp 77/0", cpu_rdata, cpu_stall); else passed++;
    cpu_read = 0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_conflict();
    test_write_hit();
    test_write_miss();
    test_flush();
    test_reset_mid_miss();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
